// File: rtl/secant_sequencer.sv
// Purpose: runs a secant solver loop: apply the solver's current reference, let the plant settle, average samples, test convergence.
// Latency: SETTLE + 2^NSAMP_LOG2 + 3 cycles per evaluation; done is a one-cycle pulse after the final evaluation.
// Backpressure: none; start is ignored while busy and abort drops any run back to IDLE on the next edge.
module secant_sequencer #(
  parameter int WIDTH      = 10,
  parameter int TOL        = 30,
  parameter int SETTLE     = 16,
  parameter int NSAMP_LOG2 = 2,
  parameter int MAX_ITER   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [WIDTH-1:0]                desired_q,
  input  logic [WIDTH-1:0]                measured_q,
  input  logic [WIDTH-1:0]                solver_iref,
  output logic [WIDTH-1:0]                i_ref,
  output logic [WIDTH-1:0]                sample_q,
  output logic                            step,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic                            timeout,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_cnt
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int AW = WIDTH + NSAMP_LOG2;
  localparam int NW = NSAMP_LOG2 + 1;

  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [NW-1:0]  SAMP_LAST   = NW'((1 << NSAMP_LOG2) - 1);
  localparam logic [IW-1:0]  ITER_LAST   = IW'(MAX_ITER - 1);
  localparam logic [WIDTH:0] TOL_W       = (WIDTH + 1)'(TOL);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] i_ref_q;
  logic [WIDTH-1:0] sample_q_q;
  logic [SW-1:0]    settle_q;
  logic [NW-1:0]    scnt_q;
  logic [AW-1:0]    acc_q;
  logic [IW-1:0]    iter_q;
  logic             step_q;
  logic             busy_q;
  logic             done_q;
  logic             conv_q;
  logic             tmo_q;

  logic [WIDTH-1:0]        avg_d;
  logic signed [WIDTH:0]   diff_d;
  logic [WIDTH:0]          err_d;

  // Average of the accumulated samples and its absolute distance from the target
  always_comb begin
    avg_d  = WIDTH'(acc_q >> NSAMP_LOG2);
    diff_d = $signed({1'b0, avg_d}) - $signed({1'b0, desired_q});
    err_d  = diff_d[WIDTH] ? $unsigned(-diff_d) : $unsigned(diff_d);
  end

  // Sequencer FSM with registered status outputs; abort overrides every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_ref_q    <= '0;
      sample_q_q <= '0;
      settle_q   <= '0;
      scnt_q     <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      // i_ref deliberately holds the last applied value
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_APPLY;
            busy_q  <= 1'b1;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
          end
        end
        S_APPLY: begin
          i_ref_q  <= solver_iref;
          settle_q <= SETTLE_LOAD;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= S_SAMPLE;
            acc_q   <= '0;
            scnt_q  <= '0;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_SAMPLE: begin
          acc_q <= acc_q + AW'(measured_q);
          if (scnt_q == SAMP_LAST) begin
            state_q <= S_EVAL;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        S_EVAL: begin
          sample_q_q <= avg_d;
          if (err_d < TOL_W) begin
            state_q <= S_DONE;
            conv_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (iter_q == ITER_LAST) begin
            state_q <= S_DONE;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_STEP;
            step_q  <= 1'b1;
          end
        end
        S_STEP: begin
          step_q  <= 1'b0;
          iter_q  <= iter_q + 1'b1;
          state_q <= S_APPLY;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ref     = i_ref_q;
  assign sample_q  = sample_q_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign timeout   = tmo_q;
  assign iter_cnt  = iter_q;

endmodule

// File: doc/secant_sequencer.md
SECANT_SEQUENCER -- requirements
Module: secant_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the width of the current-reference and measurement words.
REQ-002 The block SHALL have parameter TOL, default 30, giving the convergence threshold on |error| (strict less-than).
REQ-003 The block SHALL have parameter SETTLE, default 16, giving plant settling cycles after each i_ref change (SETTLE >= 1).
REQ-004 The block SHALL have parameter NSAMP_LOG2, default 2, giving log2 of measurement samples averaged per iteration.
REQ-005 The block SHALL have parameter MAX_ITER, default 8, giving the maximum evaluations per run (MAX_ITER >= 1).
REQ-006 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-008 Port start  input  1  SHALL request a run; sampled only in IDLE.
REQ-009 Port abort  input  1  SHALL terminate any run in progress.
REQ-010 Port desired_q  input  WIDTH  SHALL be the target measurement, held stable during a run.
REQ-011 Port measured_q  input  WIDTH  SHALL be the plant measurement.
REQ-012 Port solver_iref  input  WIDTH  SHALL be the solver's proposed current reference.
REQ-013 Port i_ref  output  WIDTH  SHALL be the registered current reference applied to the plant.
REQ-014 Port sample_q  output  WIDTH  SHALL be the registered averaged measurement presented to the solver.
REQ-015 Port step  output  1  SHALL be a one-cycle pulse advancing the solver one secant iteration.
REQ-016 Port busy, done, converged, timeout  output  1 each  SHALL be status flags; iter_cnt  output  $clog2(MAX_ITER+1)  SHALL count step pulses issued in the current run.

Function
REQ-017 FSM states SHALL be IDLE, APPLY, SETTLE, SAMPLE, EVAL, STEP, DONE; busy SHALL be 1 in all states except IDLE and DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL go to APPLY and clear iter_cnt, converged, timeout.
REQ-019 APPLY (1 cycle): SHALL latch i_ref <= solver_iref, load settle counter with SETTLE-1, go to SETTLE.
REQ-020 SETTLE: SHALL decrement each cycle; at count 0, go to SAMPLE and clear the accumulator.
REQ-021 SAMPLE: SHALL add measured_q to a WIDTH+NSAMP_LOG2-bit accumulator (no overflow possible) for exactly 2^NSAMP_LOG2 cycles, then go to EVAL.
REQ-022 EVAL (1 cycle): avg = accumulator >> NSAMP_LOG2 (truncating); sample_q SHALL be loaded with avg at the EVAL exit edge.
REQ-023 EVAL: error SHALL be |avg - desired_q| computed as WIDTH+1-bit signed; error < TOL SHALL go to DONE with converged=1.
REQ-024 EVAL otherwise: iter_cnt == MAX_ITER-1 SHALL go to DONE with timeout=1; else go to STEP.
REQ-025 STEP (1 cycle): step SHALL be 1, iter_cnt SHALL increment, next state APPLY; solver_iref is sampled at the end of the following APPLY cycle.
REQ-026 DONE (1 cycle): done SHALL be 1, then go to IDLE; converged/timeout SHALL remain until the next accepted start.
REQ-027 step SHALL be 1 only in STEP; done SHALL be 1 only in DONE.
REQ-028 Latency: start sampled at edge 0 SHALL give done high in cycle SETTLE+2^NSAMP_LOG2+3 for a first-iteration convergence (23 at defaults); each extra iteration adds SETTLE+2^NSAMP_LOG2+3 cycles.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next edge with no step, no done, flags cleared, i_ref held; abort SHALL take priority over start and every transition.
REQ-030 start while busy SHALL be ignored; i_ref SHALL hold its last applied value in IDLE and DONE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, i_ref=0, sample_q=0, iter_cnt=0, step=busy=done=converged=timeout=0, counters and accumulator 0, regardless of state.
REQ-032 Release of rst SHALL leave the block in IDLE until start=1.

Verification
REQ-033 measured_q=260, desired_q=258, solver_iref=500, start pulse -> i_ref=500 from cycle 2, no step, done in cycle 23, converged=1, sample_q=260, iter_cnt=0.
REQ-034 measured_q=600, desired_q=258 constant -> 7 step pulses, done in cycle 184, timeout=1, converged=0, iter_cnt=7.
REQ-035 measured_q alternating 100/103 in SAMPLE -> sample_q=101 (406>>2).
REQ-036 measured_q=288, desired_q=258 (error=TOL) -> not converged, step issued; measured_q=287 -> converged.
REQ-037 abort during SETTLE -> IDLE next cycle, busy=0, done never asserted, i_ref unchanged; rst asserted mid-SAMPLE -> all outputs 0 without waiting for a clock edge.
